irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Memory-mapped priority interrupt controller in the device window (base 0x00007F20). It collects up to N device interrupt lines and presents a single registered int_req to the multi-cycle controller. It latches the serviced source ID on acknowledge and holds further requests until eret. Software programs the mask and trigger mode and reads the cause through the 4-word register window.

Parameters:
N_SRC, 6, number of interrupt sources (1..16)
BASE_ADDR, 32'h00007F20, word-aligned base of the register window

Ports:
clk  in  1  system clock, all state changes on posedge
rst_n  in  1  synchronous active-low reset
irq_src  in  N_SRC  device interrupt lines, active-high
sel  in  1  CPU access targets this block (address decode done upstream)
addr  in  2  word offset, addr[3:2]: 0 MASK, 1 PENDING, 2 CAUSE, 3 CTRL
we  in  1  write strobe, valid with sel
din  in  32  write data
dout  out  32  read data, combinational from addr
int_ack  in  1  one-cycle pulse: CPU has entered the interrupt state
eret  in  1  one-cycle pulse: CPU executed eret
int_req  out  1  registered interrupt request to the controller
irq_id  out  4  ID of the source in service, valid in SERVICE

Behaviour:
- Reset (rst_n=0 at posedge) clears MASK, PENDING, CTRL, the edge-detect history, irq_id and int_req, and enters IDLE. A reset mid-service drops int_req and the service record.
- CTRL bit0 GEN (global enable), bit1 EDGE (1 = rising-edge trigger, 0 = level). Other bits read 0.
- Level mode: PENDING[i] <= irq_src[i] every cycle. Writes to PENDING are ignored.
- Edge mode: PENDING[i] is set when irq_src[i] is 1 and the previous sample was 0.
  - A write to PENDING with din[i]=1 clears bit i (W1C).
  - On int_ack, the bit of the selected source is cleared.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Eligible = PENDING & MASK[N_SRC-1:0] & {N_SRC{GEN}}. Priority is fixed: the lowest index wins.
- The FSM is registered, one transition per posedge:
  - IDLE: if eligible is nonzero, go to REQ, latch the winning ID into irq_id, and set int_req=1.
  - REQ: int_req stays 1.
    - If int_ack, go to SERVICE with int_req=0.
    - If eligible becomes zero before the ack (source dropped or masked), go back to IDLE with int_req=0.
    - A higher-priority source arriving in REQ updates irq_id.
  - SERVICE: int_req=0. New requests stay pending only. On eret, go to IDLE; a still-eligible source re-requests on the following posedge.
  - int_ack in IDLE or SERVICE is ignored. eret outside SERVICE is ignored.
- Latency: a source rising before posedge k sets PENDING at k; int_req is high after posedge k+1.
- CAUSE read: bit31 = 1 when in SERVICE, bits 3:0 = irq_id, bits N_SRC+7:8 = eligible snapshot.
- MASK is read/write; bits at or above N_SRC read 0. CAUSE writes are ignored.
- If a register write and an FSM transition land in the same cycle, the FSM samples the pre-write values.
- dout = 0 when sel=0.

Optional Feature:
IRQ_SYNC_EN.
- Defined: each irq_src bit passes through a 2-flop synchronizer before edge detect and pending, which adds 2 cycles to the latency (int_req after posedge k+3). The synchronizer flops reset to 0.
- Undefined: irq_src is sampled directly with the latency above.

Test Plan:
- Reset then level mode: CTRL=1, MASK=0x01, raise irq_src=0x01 before posedge k -> int_req=1 after posedge k+1, irq_id=0. Pulse int_ack -> int_req=0, CAUSE=0x80000000|eligible.
- Priority: MASK=0x3F, irq_src=0x24 at once -> irq_id=2. Ack, then eret with src still 0x24 -> int_req re-asserts 1 cycle later, irq_id=2.
- Edge mode W1C: CTRL=3, pulse irq_src[4] for 1 cycle -> PENDING=0x10. Write PENDING=0x10 in the same cycle as a new src[4] edge -> PENDING stays 0x10.
- Mask and withdraw: in REQ with irq_id=1, write MASK=0 -> FSM returns to IDLE, int_req=0, PENDING unchanged.
- Nesting blocked: in SERVICE, raise irq_src[0] -> int_req stays 0. After eret -> int_req=1, irq_id=0.
- Reset mid-service: rst_n=0 in SERVICE -> next posedge int_req=0, CAUSE=0, MASK=0. With IRQ_SYNC_EN defined, the scenario-1 latency becomes k+3.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// CPU-side bus and interrupt handshake bundle for irq_ctrl.
// The master is the CPU/controller side and the slave is the interrupt controller.
interface irq_ctrl_if;
   logic        sel;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        int_ack;
   logic        eret;
   logic        int_req;
   logic [3:0]  irq_id;

   modport master (
      output sel, addr, we, din, int_ack, eret,
      input  dout, int_req, irq_id
   );

   modport slave (
      input  sel, addr, we, din, int_ack, eret,
      output dout, int_req, irq_id
   );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with a MASK/PENDING/CAUSE/CTRL register window.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_src line.
module irq_ctrl #(
   parameter int unsigned N_SRC     = 6,
   parameter logic [31:0] BASE_ADDR = 32'h00007F20
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_SRC-1:0] i_irq_src,
   irq_ctrl_if.slave        bus
);

   localparam logic [1:0] ADDR_MASK  = 2'd0;
   localparam logic [1:0] ADDR_PEND  = 2'd1;
   localparam logic [1:0] ADDR_CAUSE = 2'd2;
   localparam logic       BASE_OK    = (BASE_ADDR[1:0] == 2'b00);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } state_t;

   state_t           r_state;
   logic [N_SRC-1:0] r_mask;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_prev;
   logic             r_gen;
   logic             r_edge;
   logic             r_intReq;
   logic [3:0]       r_irqId;

   logic [N_SRC-1:0] w_src;
   logic [N_SRC-1:0] w_eligible;
   logic [N_SRC-1:0] w_setBits;
   logic [N_SRC-1:0] w_clrBits;
   logic [N_SRC-1:0] w_ackBit;
   logic [N_SRC-1:0] w_w1cBits;
   logic [3:0]       w_winId;
   logic             w_anyEligible;
   logic             w_wrEn;
   logic             w_ackTaken;
   logic [31:0]      w_cause;
   logic [31:0]      w_dout;
   logic             w_unusedDin;

`ifdef IRQ_SYNC_EN
   logic [N_SRC-1:0] r_sync1;
   logic [N_SRC-1:0] r_sync2;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_irq_src;
         r_sync2 <= r_sync1;
      end
   end

   assign w_src = r_sync2;
`else
   assign w_src = i_irq_src;
`endif

   assign w_eligible    = r_pending & r_mask & {N_SRC{r_gen}};
   assign w_anyEligible = |w_eligible;
   assign w_wrEn        = bus.sel & bus.we & BASE_OK;
   assign w_unusedDin   = ^bus.din;

   // Lowest index wins, so scan downward and let the last hit stand.
   always_comb begin
      w_winId = 4'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_winId = 4'(i);
         end
      end
   end

   assign w_ackTaken = (r_state == REQ) & bus.int_ack & w_anyEligible;

   always_comb begin
      w_ackBit = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_ackBit[i] = w_ackTaken && (w_winId == 4'(i));
      end
   end

   assign w_w1cBits = (w_wrEn && (bus.addr == ADDR_PEND)) ? bus.din[N_SRC-1:0] : '0;
   assign w_setBits = w_src & ~r_prev;
   assign w_clrBits = w_w1cBits | w_ackBit;

   // Set is OR-ed in after the clear so a coincident edge survives a W1C or ack.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mask    <= '0;
         r_pending <= '0;
         r_prev    <= '0;
         r_gen     <= 1'b0;
         r_edge    <= 1'b0;
      end else begin
         r_prev <= w_src;
         if (r_edge) begin
            r_pending <= (r_pending & ~w_clrBits) | w_setBits;
         end else begin
            r_pending <= w_src;
         end
         if (w_wrEn && (bus.addr == ADDR_MASK)) begin
            r_mask <= bus.din[N_SRC-1:0];
         end
         if (w_wrEn && (bus.addr == 2'd3)) begin
            r_gen  <= bus.din[0];
            r_edge <= bus.din[1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_intReq <= 1'b0;
         r_irqId  <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyEligible) begin
                  r_state  <= REQ;
                  r_intReq <= 1'b1;
                  r_irqId  <= w_winId;
               end
            end
            REQ: begin
               if (!w_anyEligible) begin
                  r_state  <= IDLE;
                  r_intReq <= 1'b0;
               end else begin
                  r_irqId <= w_winId;
                  if (bus.int_ack) begin
                     r_state  <= SERVICE;
                     r_intReq <= 1'b0;
                  end
               end
            end
            SERVICE: begin
               r_intReq <= 1'b0;
               if (bus.eret) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_intReq <= 1'b0;
            end
         endcase
      end
   end

   assign w_cause = {(r_state == SERVICE), 31'd0}
                  | (32'(w_eligible) << 8)
                  | {28'd0, r_irqId};

   always_comb begin
      w_dout = 32'd0;
      if (bus.sel) begin
         case (bus.addr)
            ADDR_MASK:  w_dout = 32'(r_mask);
            ADDR_PEND:  w_dout = 32'(r_pending);
            ADDR_CAUSE: w_dout = w_cause;
            default:    w_dout = {30'd0, r_edge, r_gen};
         endcase
      end
   end

   assign bus.dout    = w_dout;
   assign bus.int_req = r_intReq;
   assign bus.irq_id  = r_irqId;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: each scenario queues its expected outputs,
// then the queue is drained against the DUT between clock edges.
module tb_irq_ctrl;
   localparam int N_SRC = 6;
`ifdef IRQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam logic [1:0] ADDR_MASK  = 2'd0;
   localparam logic [1:0] ADDR_PEND  = 2'd1;
   localparam logic [1:0] ADDR_CAUSE = 2'd2;
   localparam logic [1:0] ADDR_CTRL  = 2'd3;
   localparam int OBS_REQ   = 0;
   localparam int OBS_ID    = 1;
   localparam int OBS_REG   = 2;
   localparam int OBS_NOSEL = 3;

   typedef struct {
      string       tag;
      int          kind;
      logic [1:0]  addr;
      logic [31:0] exp;
   } sbEntry_t;

   sbEntry_t sbQ[$];
   int checks = 0;
   int errors = 0;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic [N_SRC-1:0] irqSrc = '0;

   irq_ctrl_if bus ();

   irq_ctrl #(
      .N_SRC(N_SRC),
      .BASE_ADDR(32'h00007F20)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_irq_src(irqSrc),
      .bus(bus.slave)
   );

   always #10 clk = ~clk;

   task automatic stepClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expectVal(input string tag, input int kind, input logic [1:0] a, input logic [31:0] e);
      sbEntry_t en;
      en.tag  = tag;
      en.kind = kind;
      en.addr = a;
      en.exp  = e;
      sbQ.push_back(en);
   endtask

   // Reads go through the combinational dout path, well before the next edge.
   task automatic drainScoreboard();
      sbEntry_t    en;
      logic [31:0] obs;
      while (sbQ.size() > 0) begin
         en = sbQ.pop_front();
         case (en.kind)
            OBS_REQ: obs = {31'd0, bus.int_req};
            OBS_ID:  obs = {28'd0, bus.irq_id};
            OBS_REG: begin
               bus.sel  = 1'b1;
               bus.we   = 1'b0;
               bus.addr = en.addr;
               #1;
               obs     = bus.dout;
               bus.sel = 1'b0;
            end
            default: begin
               bus.sel  = 1'b0;
               bus.we   = 1'b0;
               bus.addr = en.addr;
               #1;
               obs = bus.dout;
            end
         endcase
         checkOutput(en.tag, obs, en.exp);
      end
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      bus.sel  = 1'b1;
      bus.we   = 1'b1;
      bus.addr = a;
      bus.din  = d;
      stepClk(1);
      bus.sel = 1'b0;
      bus.we  = 1'b0;
      bus.din = 32'd0;
   endtask

   task automatic applyStimulus(input logic [N_SRC-1:0] src, input logic ack, input logic eret);
      irqSrc      = src;
      bus.int_ack = ack;
      bus.eret    = eret;
      stepClk(1);
      bus.int_ack = 1'b0;
      bus.eret    = 1'b0;
   endtask

   task automatic doReset();
      rstN        = 1'b0;
      irqSrc      = '0;
      bus.sel     = 1'b0;
      bus.we      = 1'b0;
      bus.addr    = 2'd0;
      bus.din     = 32'd0;
      bus.int_ack = 1'b0;
      bus.eret    = 1'b0;
      stepClk(2);
      rstN = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting irq_ctrl bench, sync latency %0d", SYNC_LAT);

      // Reset values
      doReset();
      expectVal("rst_int_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("rst_irq_id", OBS_ID, 2'd0, 32'd0);
      expectVal("rst_mask", OBS_REG, ADDR_MASK, 32'd0);
      expectVal("rst_pend", OBS_REG, ADDR_PEND, 32'd0);
      expectVal("rst_cause", OBS_REG, ADDR_CAUSE, 32'd0);
      expectVal("rst_ctrl", OBS_REG, ADDR_CTRL, 32'd0);
      drainScoreboard();

      // Level mode latency, ack and eret
      busWrite(ADDR_CTRL, 32'h1);
      busWrite(ADDR_MASK, 32'h1);
      expectVal("ctrl_rd", OBS_REG, ADDR_CTRL, 32'h1);
      drainScoreboard();
      irqSrc = 6'h01;
      stepClk(1 + SYNC_LAT);
      expectVal("lat_req_k", OBS_REQ, 2'd0, 32'd0);
      expectVal("lat_pend_k", OBS_REG, ADDR_PEND, 32'h1);
      drainScoreboard();
      stepClk(1);
      expectVal("lat_req_k1", OBS_REQ, 2'd0, 32'd1);
      expectVal("lat_id_k1", OBS_ID, 2'd0, 32'd0);
      drainScoreboard();
      applyStimulus(6'h01, 1'b1, 1'b0);
      expectVal("ack_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("ack_cause", OBS_REG, ADDR_CAUSE, 32'h80000100);
      drainScoreboard();
      irqSrc = 6'h00;
      stepClk(1 + SYNC_LAT);
      expectVal("svc_cause_drop", OBS_REG, ADDR_CAUSE, 32'h80000000);
      drainScoreboard();
      applyStimulus(6'h00, 1'b0, 1'b1);
      stepClk(1);
      expectVal("eret_idle_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("eret_idle_cause", OBS_REG, ADDR_CAUSE, 32'd0);
      drainScoreboard();

      // Priority and re-request after eret
      doReset();
      busWrite(ADDR_CTRL, 32'h1);
      busWrite(ADDR_MASK, 32'h3F);
      irqSrc = 6'h24;
      stepClk(2 + SYNC_LAT);
      expectVal("prio_req", OBS_REQ, 2'd0, 32'd1);
      expectVal("prio_id", OBS_ID, 2'd0, 32'd2);
      drainScoreboard();
      applyStimulus(6'h24, 1'b1, 1'b0);
      expectVal("prio_ack_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("prio_ack_cause", OBS_REG, ADDR_CAUSE, 32'h80002402);
      drainScoreboard();
      applyStimulus(6'h24, 1'b0, 1'b1);
      expectVal("prio_eret_req", OBS_REQ, 2'd0, 32'd0);
      drainScoreboard();
      stepClk(1);
      expectVal("prio_rereq", OBS_REQ, 2'd0, 32'd1);
      expectVal("prio_rereq_id", OBS_ID, 2'd0, 32'd2);
      drainScoreboard();

      // Edge mode, W1C, set-beats-clear, ack clears the serviced bit
      doReset();
      busWrite(ADDR_CTRL, 32'h3);
      applyStimulus(6'h10, 1'b0, 1'b0);
      irqSrc = 6'h00;
      stepClk(SYNC_LAT);
      expectVal("edge_set", OBS_REG, ADDR_PEND, 32'h10);
      drainScoreboard();
      stepClk(1);
      expectVal("edge_hold", OBS_REG, ADDR_PEND, 32'h10);
      drainScoreboard();
      busWrite(ADDR_PEND, 32'h10);
      expectVal("edge_w1c", OBS_REG, ADDR_PEND, 32'h00);
      drainScoreboard();
      applyStimulus(6'h10, 1'b0, 1'b0);
      irqSrc = 6'h00;
      stepClk(SYNC_LAT + 1);
      expectVal("edge_reset", OBS_REG, ADDR_PEND, 32'h10);
      drainScoreboard();
      irqSrc = 6'h10;
`ifdef IRQ_SYNC_EN
      stepClk(1);
      irqSrc = 6'h00;
      stepClk(SYNC_LAT - 1);
      busWrite(ADDR_PEND, 32'h10);
`else
      busWrite(ADDR_PEND, 32'h10);
      irqSrc = 6'h00;
`endif
      expectVal("edge_set_wins", OBS_REG, ADDR_PEND, 32'h10);
      drainScoreboard();
      stepClk(1 + SYNC_LAT);
      busWrite(ADDR_MASK, 32'h10);
      stepClk(1);
      expectVal("edge_req", OBS_REQ, 2'd0, 32'd1);
      expectVal("edge_id", OBS_ID, 2'd0, 32'd4);
      drainScoreboard();
      applyStimulus(6'h00, 1'b1, 1'b0);
      expectVal("edge_ack_clr", OBS_REG, ADDR_PEND, 32'h00);
      expectVal("edge_ack_cause", OBS_REG, ADDR_CAUSE, 32'h80000004);
      drainScoreboard();

      // Mask withdraw in REQ, then higher priority preempts irq_id
      doReset();
      busWrite(ADDR_CTRL, 32'h1);
      busWrite(ADDR_MASK, 32'h3F);
      irqSrc = 6'h02;
      stepClk(2 + SYNC_LAT);
      expectVal("wd_req", OBS_REQ, 2'd0, 32'd1);
      expectVal("wd_id", OBS_ID, 2'd0, 32'd1);
      drainScoreboard();
      busWrite(ADDR_MASK, 32'h0);
      expectVal("wd_prewrite_req", OBS_REQ, 2'd0, 32'd1);
      expectVal("wd_mask_rd", OBS_REG, ADDR_MASK, 32'h0);
      drainScoreboard();
      stepClk(1);
      expectVal("wd_idle_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("wd_pend", OBS_REG, ADDR_PEND, 32'h02);
      expectVal("wd_cause", OBS_REG, ADDR_CAUSE, 32'h00000001);
      drainScoreboard();
      busWrite(ADDR_MASK, 32'hFFFF_FFFF);
      expectVal("mask_hi_bits", OBS_REG, ADDR_MASK, 32'h3F);
      expectVal("nosel_dout", OBS_NOSEL, ADDR_MASK, 32'h0);
      drainScoreboard();
      stepClk(1);
      irqSrc = 6'h03;
      stepClk(1 + SYNC_LAT);
      expectVal("preempt_old_id", OBS_ID, 2'd0, 32'd1);
      drainScoreboard();
      stepClk(1);
      expectVal("preempt_new_id", OBS_ID, 2'd0, 32'd0);
      expectVal("preempt_req", OBS_REQ, 2'd0, 32'd1);
      drainScoreboard();

      // Nesting blocked in SERVICE
      doReset();
      busWrite(ADDR_CTRL, 32'h1);
      busWrite(ADDR_MASK, 32'h3F);
      irqSrc = 6'h08;
      stepClk(2 + SYNC_LAT);
      applyStimulus(6'h08, 1'b1, 1'b0);
      irqSrc = 6'h09;
      stepClk(3 + SYNC_LAT);
      expectVal("nest_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("nest_cause", OBS_REG, ADDR_CAUSE, 32'h80000903);
      drainScoreboard();
      applyStimulus(6'h09, 1'b0, 1'b1);
      expectVal("nest_eret_req", OBS_REQ, 2'd0, 32'd0);
      drainScoreboard();
      stepClk(1);
      expectVal("nest_rereq", OBS_REQ, 2'd0, 32'd1);
      expectVal("nest_rereq_id", OBS_ID, 2'd0, 32'd0);
      drainScoreboard();

      // Reset in SERVICE, then GEN=0 suppresses requests
      applyStimulus(6'h09, 1'b1, 1'b0);
      rstN = 1'b0;
      stepClk(1);
      expectVal("midrst_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("midrst_cause", OBS_REG, ADDR_CAUSE, 32'd0);
      expectVal("midrst_mask", OBS_REG, ADDR_MASK, 32'd0);
      expectVal("midrst_ctrl", OBS_REG, ADDR_CTRL, 32'd0);
      drainScoreboard();
      rstN = 1'b1;
      busWrite(ADDR_MASK, 32'h3F);
      stepClk(3 + SYNC_LAT);
      expectVal("gen0_req", OBS_REQ, 2'd0, 32'd0);
      expectVal("gen0_pend", OBS_REG, ADDR_PEND, 32'h09);
      expectVal("gen0_cause", OBS_REG, ADDR_CAUSE, 32'd0);
      drainScoreboard();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
